// File: rtl/mmio_port_responder_pkg.sv
// Shared register map, window geometry and control/status bit positions
// for the MMIO port/timer responder.
package mmio_port_responder_pkg;

    localparam int WINDOW_BYTES = 64;

    localparam logic [5:0] OFF_PORT_OUT     = 6'h00;
    localparam logic [5:0] OFF_PORT_IN      = 6'h04;
    localparam logic [5:0] OFF_IN_EDGE      = 6'h08;
    localparam logic [5:0] OFF_TIMER_LOAD   = 6'h0C;
    localparam logic [5:0] OFF_TIMER_CTRL   = 6'h10;
    localparam logic [5:0] OFF_TIMER_STATUS = 6'h14;
    localparam logic [5:0] OFF_TIMER_COUNT  = 6'h18;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int STATUS_EXP_BIT = 0;

    // Word index (Address[5:2]) to byte offset within the window.
    function automatic logic [5:0] word_off(input logic [3:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/mmio_port_responder_port_in_sync.sv
// Two-flop synchroniser for the external input pins plus a third flop
// holding the previous synchronised value for rising-edge detection.
module port_in_sync #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [W-1:0] pin_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped responder: output port, synchronised input port with sticky
// rising-edge flags, and a down-counting timer with expiry interrupt.
module mmio_port_responder
    import mmio_port_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
    parameter logic [31:0] RESET_PORT_OUT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        TimerIrq
);

    logic [31:0] port_out_q, port_out_d;
    logic [7:0]  in_edge_q, in_edge_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        exp_q, exp_d;

    logic [7:0]  pin_sync, pin_rise;
    logic [5:0]  off;
    logic        wr_en, expire;
    logic        unused_addr_lo;

    port_in_sync #(.W(8)) u_port_in_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (PortIn),
        .sync_o  (pin_sync),
        .rise_o  (pin_rise)
    );

    assign Hit            = (Address[31:6] == BASE_ADDR[31:6]);
    assign off            = word_off(Address[5:2]);
    assign unused_addr_lo = ^Address[1:0];
    assign wr_en          = MemWrite & Hit;
    assign expire         = en_q && (count_q == 32'd0);

    always_comb begin
        port_out_d = port_out_q;
        in_edge_d  = in_edge_q;
        load_d     = load_q;
        count_d    = count_q;
        en_d       = en_q;
        auto_d     = auto_q;
        exp_d      = exp_q;

        if (wr_en && off == OFF_PORT_OUT)
            port_out_d = WriteData;

        // Hardware set wins over a same-cycle W1C.
        if (wr_en && off == OFF_IN_EDGE)
            in_edge_d = in_edge_q & ~WriteData[7:0];
        in_edge_d = in_edge_d | pin_rise;

        if (wr_en && off == OFF_TIMER_LOAD) begin
            load_d  = WriteData;
            count_d = WriteData;
        end else if (en_q) begin
            if (count_q != 32'd0)
                count_d = count_q - 32'd1;
            else
                count_d = auto_q ? load_q : 32'd0;
        end

        // A software CTRL write beats the one-shot auto-disable.
        if (wr_en && off == OFF_TIMER_CTRL) begin
            en_d   = WriteData[CTRL_EN_BIT];
            auto_d = WriteData[CTRL_AUTO_BIT];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        if (wr_en && off == OFF_TIMER_STATUS && WriteData[STATUS_EXP_BIT])
            exp_d = 1'b0;
        if (expire)
            exp_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            port_out_q <= RESET_PORT_OUT;
            in_edge_q  <= '0;
            load_q     <= '0;
            count_q    <= '0;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            exp_q      <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            in_edge_q  <= in_edge_d;
            load_q     <= load_d;
            count_q    <= count_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            exp_q      <= exp_d;
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && Hit) begin
            case (off)
                OFF_PORT_OUT:     ReadData = port_out_q;
                OFF_PORT_IN:      ReadData = {24'h0, pin_sync};
                OFF_IN_EDGE:      ReadData = {24'h0, in_edge_q};
                OFF_TIMER_LOAD:   ReadData = load_q;
                OFF_TIMER_CTRL:   ReadData = {30'h0, auto_q, en_q};
                OFF_TIMER_STATUS: ReadData = {31'h0, exp_q};
                OFF_TIMER_COUNT:  ReadData = count_q;
                default:          ReadData = 32'h0;
            endcase
        end
    end

    assign PortOut  = port_out_q;
    assign TimerIrq = exp_q;

endmodule

// File: doc/mmio_port_responder.md
MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1001_0000, byte address of the 64-byte register window (aligned to 64).
REQ-002 Parameter RESET_PORT_OUT, default 32'h0000_0000, reset value of PortOut.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Address  input  32  processor data-bus byte address (ME-stage ALU result).
REQ-006 WriteData  input  32  processor store data.
REQ-007 MemWrite  input  1  store strobe, one cycle per store.
REQ-008 MemRead  input  1  load strobe.
REQ-009 ReadData  output  32  load data, combinational.
REQ-010 Hit  output  1  combinational, high when Address[31:6] == BASE_ADDR[31:6].
REQ-011 PortIn  input  8  asynchronous external input pins.
REQ-012 PortOut  output  32  registered external output port.
REQ-013 TimerIrq  output  1  registered, equal to the TIMER_STATUS expired bit.

Function
REQ-014 The register map SHALL use offset = Address[5:2]*4; Address[1:0] ignored. 0x00 PORT_OUT RW; 0x04 PORT_IN RO; 0x08 IN_EDGE R/W1C; 0x0C TIMER_LOAD RW; 0x10 TIMER_CTRL RW (bit0 EN, bit1 AUTO); 0x14 TIMER_STATUS R/W1C (bit0 EXP); 0x18 TIMER_COUNT RO.
REQ-015 Reads SHALL be zero-latency: ReadData = selected register when MemRead & Hit, else 32'h0; unused bits read 0.
REQ-016 Writes SHALL take effect at the clock edge on which MemWrite & Hit is high; writes to RO or unmapped offsets (0x1C-0x3C) have no effect.
REQ-017 When Hit is low, the block SHALL change no state and SHALL drive ReadData = 0, whatever MemRead/MemWrite are.
REQ-018 PortIn SHALL pass through a two-flop synchroniser. PORT_IN reads {24'h0, sync2}: a PortIn change is visible 2 edges later.
REQ-019 A third flop SHALL hold the previous sync2. A rising edge on bit i (sync2 & ~prev) sets IN_EDGE[i] on the next edge, i.e. 3 edges after the PortIn change.
REQ-020 IN_EDGE bits SHALL be sticky, cleared by writing 1 to that bit. A same-cycle set and clear on one bit leaves the bit set.
REQ-021 A write to TIMER_LOAD SHALL update both LOAD and COUNT. It takes priority over a decrement in the same cycle.
REQ-022 If EN=1 and COUNT != 0, COUNT SHALL decrement by 1 per cycle. If EN=0, COUNT holds.
REQ-023 If EN=1 and COUNT == 0 on an edge, EXP SHALL be set. If AUTO=1, COUNT reloads LOAD. If AUTO=0, EN clears and COUNT stays 0.
REQ-024 With AUTO=1 and LOAD=N, EXP SHALL be set every N+1 cycles. With LOAD=0 and AUTO=1, EXP is set every cycle.
REQ-025 EXP is W1C. A same-cycle expiry and W1C leaves EXP set. A CTRL write in the expiry cycle takes priority over the hardware EN clear.
REQ-026 COUNT arithmetic SHALL be 32-bit unsigned and SHALL never wrap below 0.

Reset
REQ-027 On a reset edge: PortOut = RESET_PORT_OUT; sync flops, prev flop, IN_EDGE, LOAD, COUNT, CTRL, EXP and TimerIrq = 0.
REQ-028 Reset SHALL override any concurrent write, decrement or edge detection. ReadData and Hit remain combinational during reset.

Structure
REQ-029 A shared package SHALL hold the register offset constants, the window size (64), and the CTRL/STATUS bit positions.
REQ-030 One sub-module, port_in_sync, SHALL contain the 3-flop synchroniser and edge detector. It outputs sync value[7:0] and rise[7:0].

Verification
REQ-031 Store 32'hDEAD_BEEF to BASE+0x00 -> PortOut = 32'hDEAD_BEEF the next cycle; a load from BASE+0x00 returns the same value.
REQ-032 PortIn goes 8'h00 -> 8'h05 -> PORT_IN reads 5 after 2 edges and IN_EDGE reads 5 after 3 edges. Writing 1 to IN_EDGE leaves 4; a held input sets no new flag.
REQ-033 LOAD=3, CTRL=3 (EN|AUTO) -> EXP/TimerIrq rise 4 cycles after the CTRL write edge and recur every 4 cycles. W1C to STATUS clears EXP for 3 cycles.
REQ-034 LOAD=2, CTRL=1 (one-shot) -> after expiry COUNT=0, EN=0, EXP=1, and no further expiry.
REQ-035 Store to 32'h1001_0040 (outside window) -> Hit=0, ReadData=0, no register changes. Asserting reset mid-count -> all state zero, PortOut = RESET_PORT_OUT the next cycle.
